// File: rtl/graphic_manager.sv
// ILI9341 8080-16 write-only driver: power-up init plus single-pixel writes.
// Define CLEAR_ON_INIT_EN to black-fill the whole panel before initialized rises.
module graphic_manager #(
  parameter int RESET_LOW_CYCLES  = 500,
  parameter int RESET_WAIT_CYCLES = 250000,
  parameter int SLEEP_OUT_CYCLES  = 6000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [8:0]  pixel_col,
  input  logic [7:0]  pixel_row,
  input  logic        write_pixel,
  input  logic        bw_pixel_color,
  output logic        initialized,
  output logic        tft_rst,
  output logic        tft_csx,
  output logic        tft_dcx,
  output logic        tft_wrx,
  output logic        tft_rdx,
  output logic [15:0] tft_data
);

  localparam logic [2:0] S_RST_LOW  = 3'd0;
  localparam logic [2:0] S_RST_WAIT = 3'd1;
  localparam logic [2:0] S_XFER     = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_IDLE     = 3'd4;

  localparam logic [2:0] ST_SWRST  = 3'd0;
  localparam logic [2:0] ST_SLPOUT = 3'd1;
  localparam logic [2:0] ST_COLMOD = 3'd2;
  localparam logic [2:0] ST_MADCTL = 3'd3;
  localparam logic [2:0] ST_DISPON = 3'd4;
  localparam logic [2:0] ST_CLEAR  = 3'd5;
  localparam logic [2:0] ST_PIX    = 3'd6;

  localparam logic [16:0] PIX_LAST   = 17'd11;
  localparam logic [16:0] CLEAR_LAST = 17'd76810;

  logic [2:0]  r_state;
  logic [2:0]  r_step;
  logic [31:0] r_cnt;
  logic [31:0] r_wlen;
  logic [16:0] r_idx;
  logic        r_ph;

  logic        r_wp;
  logic        r_wp_d;
  logic [8:0]  r_in_col;
  logic [7:0]  r_in_row;
  logic        r_in_clr;
  logic [8:0]  r_col;
  logic [7:0]  r_row;
  logic        r_clr;

  logic        r_init;
  logic        r_rst;
  logic        r_csx;
  logic        r_dcx;
  logic        r_wrx;
  logic [15:0] r_data;

  logic [8:0]  w_cs;
  logic [8:0]  w_ce;
  logic [7:0]  w_rs;
  logic [7:0]  w_re;
  logic        w_pc;
  logic [16:0] w_win;
  logic [16:0] w_word;
  logic [16:0] w_last;
  logic [31:0] w_wlen;
  logic [2:0]  w_next;
  logic        w_xfer;
  logic        w_req;

  assign initialized = r_init;
  assign tft_rst     = r_rst;
  assign tft_csx     = r_csx;
  assign tft_dcx     = r_dcx;
  assign tft_wrx     = r_wrx;
  assign tft_rdx     = 1'b1;
  assign tft_data    = r_data;

  // Window/fill words: {dcx, data}; the clear fill reuses the pixel layout.
  always_comb begin
    w_cs = r_col;
    w_ce = r_col;
    w_rs = r_row;
    w_re = r_row;
    w_pc = r_clr;
    if (r_step == ST_CLEAR) begin
      w_cs = 9'd0;
      w_ce = 9'd319;
      w_rs = 8'd0;
      w_re = 8'd239;
      w_pc = 1'b0;
    end
    case (r_idx)
      17'd0:   w_win = {1'b0, 16'h002A};
      17'd1:   w_win = {1'b1, 15'd0, w_cs[8]};
      17'd2:   w_win = {1'b1, 8'h00, w_cs[7:0]};
      17'd3:   w_win = {1'b1, 15'd0, w_ce[8]};
      17'd4:   w_win = {1'b1, 8'h00, w_ce[7:0]};
      17'd5:   w_win = {1'b0, 16'h002B};
      17'd6:   w_win = {1'b1, 16'h0000};
      17'd7:   w_win = {1'b1, 8'h00, w_rs};
      17'd8:   w_win = {1'b1, 16'h0000};
      17'd9:   w_win = {1'b1, 8'h00, w_re};
      17'd10:  w_win = {1'b0, 16'h002C};
      default: w_win = {1'b1, {16{w_pc}}};
    endcase
  end

  always_comb begin
    w_word = w_win;
    w_last = PIX_LAST;
    w_wlen = 32'd1;
    w_next = S_WAIT;
    unique case (1'b1)
      r_step == ST_SWRST: begin
        w_word = {1'b0, 16'h0001};
        w_last = 17'd0;
        w_wlen = 32'(RESET_WAIT_CYCLES);
      end
      r_step == ST_SLPOUT: begin
        w_word = {1'b0, 16'h0011};
        w_last = 17'd0;
        w_wlen = 32'(SLEEP_OUT_CYCLES);
      end
      r_step == ST_COLMOD: begin
        w_word = r_idx[0] ? {1'b1, 16'h0055}
                          : {1'b0, 16'h003A};
        w_last = 17'd1;
      end
      r_step == ST_MADCTL: begin
        w_word = r_idx[0] ? {1'b1, 16'h0028}
                          : {1'b0, 16'h0036};
        w_last = 17'd1;
      end
      r_step == ST_DISPON: begin
        w_word = {1'b0, 16'h0029};
        w_last = 17'd0;
`ifdef CLEAR_ON_INIT_EN
        w_next = S_WAIT;
`else
        w_next = S_IDLE;
`endif
      end
      r_step == ST_CLEAR: begin
        w_last = CLEAR_LAST;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_xfer = (r_state == S_XFER);
  assign w_req  = (r_state == S_IDLE) && r_init
               && r_wp && !r_wp_d
               && (r_in_col <= 9'd319)
               && (r_in_row <= 8'd239);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_RST_LOW;
      r_step   <= ST_SWRST;
      r_cnt    <= '0;
      r_wlen   <= 32'd1;
      r_idx    <= '0;
      r_ph     <= 1'b0;
      r_wp     <= 1'b0;
      r_wp_d   <= 1'b0;
      r_in_col <= '0;
      r_in_row <= '0;
      r_in_clr <= 1'b0;
      r_col    <= '0;
      r_row    <= '0;
      r_clr    <= 1'b0;
      r_init   <= 1'b0;
      r_rst    <= 1'b0;
      r_csx    <= 1'b1;
      r_dcx    <= 1'b1;
      r_wrx    <= 1'b1;
      r_data   <= '0;
    end else if (en) begin
      r_wp     <= write_pixel;
      r_wp_d   <= r_wp;
      r_in_col <= pixel_col;
      r_in_row <= pixel_row;
      r_in_clr <= bw_pixel_color;
      // Pins are a registered image of the current state and word.
      r_csx    <= !w_xfer;
      r_wrx    <= !(w_xfer && !r_ph);
      r_dcx    <= w_xfer ? w_word[16] : 1'b1;
      r_data   <= w_xfer ? w_word[15:0] : 16'h0000;
      r_init   <= r_init || (r_state == S_IDLE);
      unique case (r_state)
        S_RST_LOW: begin
          if (r_cnt == 32'(RESET_LOW_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_rst   <= 1'b1;
            r_state <= S_RST_WAIT;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_RST_WAIT: begin
          if (r_cnt == 32'(RESET_WAIT_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_step  <= ST_SWRST;
            r_idx   <= '0;
            r_ph    <= 1'b0;
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_XFER: begin
          r_ph <= !r_ph;
          if (r_ph) begin
            if (r_idx == w_last) begin
              r_idx   <= '0;
              r_cnt   <= '0;
              r_wlen  <= w_wlen;
              r_step  <= r_step + 3'd1;
              r_state <= w_next;
            end else begin
              r_idx <= r_idx + 17'd1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == r_wlen - 32'd1) begin
            r_cnt   <= '0;
            r_state <= S_XFER;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (w_req) begin
            r_col   <= r_in_col;
            r_row   <= r_in_row;
            r_clr   <= r_in_clr;
            r_step  <= ST_PIX;
            r_idx   <= '0;
            r_ph    <= 1'b0;
            r_state <= S_XFER;
          end
        end
        default: r_state <= S_RST_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_graphic_manager.sv
// Randomized bench for graphic_manager: a transaction-level panel model
// decodes bus words and compares them with the words the rules predict.
module tb_graphic_manager;

  localparam int RL = 4;
  localparam int RW = 8;
  localparam int SO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic [8:0]  pixel_col = '0;
  logic [7:0]  pixel_row = '0;
  logic        write_pixel = 1'b0;
  logic        bw = 1'b0;
  logic        initialized;
  logic        tft_rst;
  logic        tft_csx;
  logic        tft_dcx;
  logic        tft_wrx;
  logic        tft_rdx;
  logic [15:0] tft_data;

  always #5 clk = ~clk;

  graphic_manager #(
    .RESET_LOW_CYCLES (RL),
    .RESET_WAIT_CYCLES(RW),
    .SLEEP_OUT_CYCLES (SO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .pixel_col     (pixel_col),
    .pixel_row     (pixel_row),
    .write_pixel   (write_pixel),
    .bw_pixel_color(bw),
    .initialized   (initialized),
    .tft_rst       (tft_rst),
    .tft_csx       (tft_csx),
    .tft_dcx       (tft_dcx),
    .tft_wrx       (tft_wrx),
    .tft_rdx       (tft_rdx),
    .tft_data      (tft_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected transactions: flat word queue plus per-transaction word counts.
  logic [16:0] exp_w[$];
  int          exp_n[$];

  task automatic push_init();
    exp_w.push_back({1'b0, 16'h0001}); exp_n.push_back(1);
    exp_w.push_back({1'b0, 16'h0011}); exp_n.push_back(1);
    exp_w.push_back({1'b0, 16'h003A});
    exp_w.push_back({1'b1, 16'h0055}); exp_n.push_back(2);
    exp_w.push_back({1'b0, 16'h0036});
    exp_w.push_back({1'b1, 16'h0028}); exp_n.push_back(2);
    exp_w.push_back({1'b0, 16'h0029}); exp_n.push_back(1);
  endtask

  task automatic push_pixel(input int col, input int row, input bit c);
    exp_w.push_back({1'b0, 16'h002A});
    for (int k = 0; k < 2; k++) begin
      exp_w.push_back({1'b1, 16'(col / 256)});
      exp_w.push_back({1'b1, 16'(col % 256)});
    end
    exp_w.push_back({1'b0, 16'h002B});
    for (int k = 0; k < 2; k++) begin
      exp_w.push_back({1'b1, 16'h0000});
      exp_w.push_back({1'b1, 16'(row)});
    end
    exp_w.push_back({1'b0, 16'h002C});
    exp_w.push_back({1'b1, c ? 16'hFFFF : 16'h0000});
    exp_n.push_back(12);
  endtask

  // Monitor state
  logic [16:0] cap[$];
  logic [16:0] last_tx[$];
  int          tx_count = 0;
  int          len = 0;
  int          last_len = 0;
  bit          in_tx = 0;
  bit          ph = 0;
  int          rst_low_cnt = 0;
  bit          rst_done = 0;
  bit          init_prev = 0;
  bit          en_prev = 1;
  bit          reset_prev = 0;
  logic [20:0] prev_bus = '0;
  logic [16:0] prev_word = '0;

  task automatic end_tx();
    int n;
    tx_count++;
    last_tx  = cap;
    last_len = len;
    chk("tx_csx_cycles", len, 2 * cap.size());
    chk("tx_phase_end", ph, 0);
    if (exp_n.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_tx: got %0d words, expected none",
               cap.size());
    end else begin
      n = exp_n.pop_front();
      chk("tx_words", cap.size(), n);
      for (int i = 0; i < n; i++) begin
        logic [16:0] w;
        w = exp_w.pop_front();
        if (i < cap.size()) chk("tx_word", cap[i], w);
      end
    end
  endtask

  always @(negedge clk) begin
    logic [20:0] bus;
    bus = {initialized, tft_rst, tft_csx, tft_dcx, tft_wrx, tft_data};
    if (!reset) begin
      chk("reset_values", {bus, tft_rdx}, {5'b00111, 16'h0000, 1'b1});
      in_tx = 0;
      cap.delete();
      rst_low_cnt = 0;
      rst_done = 0;
      init_prev = 0;
    end else if (reset_prev && !en_prev) begin
      chk("freeze", bus, prev_bus);
    end else begin
      chk("rdx", tft_rdx, 1);
      if (!tft_rst) begin
        if (rst_done) chk("tft_rst_stays_high", tft_rst, 1);
        rst_low_cnt++;
      end else if (!rst_done) begin
        rst_done = 1;
        chk("tft_rst_low_cycles", rst_low_cnt, RL);
      end
      if (!tft_csx) begin
        if (!in_tx) begin
          in_tx = 1;
          len = 0;
          ph = 0;
          cap.delete();
        end
        chk("wrx_phase", tft_wrx, ph);
        if (!ph) cap.push_back({tft_dcx, tft_data});
        else chk("hold_b", {tft_dcx, tft_data}, prev_word);
        ph = !ph;
        len++;
      end else begin
        chk("wrx_idle", tft_wrx, 1);
        if (in_tx) begin
          in_tx = 0;
          end_tx();
        end
      end
      if (init_prev) chk("init_sticky", initialized, 1);
      if (initialized && !init_prev) begin
        chk("init_after_seq", exp_n.size(), 0);
        chk("init_bus_idle", tft_csx, 1);
      end
      init_prev = initialized;
    end
    prev_word  = {tft_dcx, tft_data};
    prev_bus   = bus;
    en_prev    = en;
    reset_prev = reset;
  end

  task automatic req(input int col, input int row,
                     input bit c, input int hold);
    @(posedge clk);
    #1;
    pixel_col   = 9'(col);
    pixel_row   = 8'(row);
    bw          = c;
    write_pixel = 1'b1;
    if (col < 320 && row < 240) push_pixel(col, row, c);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      pixel_col = 9'($urandom);
      pixel_row = 8'($urandom);
      bw        = 1'($urandom);
    end
    write_pixel = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd_en);
    int k;
    k = 0;
    while (k < budget &&
           !(exp_n.size() == 0 && !in_tx && tft_csx === 1'b1)) begin
      @(posedge clk);
      #1;
      en = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL idle_timeout: waited %0d cycles, %0d tx pending",
               k, exp_n.size());
    end
  endtask

  task automatic wait_init(input int budget);
    int k;
    k = 0;
    while (k < budget && initialized !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    chk("init_timeout", initialized, 1);
  endtask

  logic [16:0] lit2[12] = '{17'h0002A, 17'h10000, 17'h10005, 17'h10000,
                            17'h10005, 17'h0002B, 17'h10000, 17'h10000,
                            17'h10000, 17'h10000, 17'h0002C, 17'h1FFFF};
  logic [16:0] lit3[12] = '{17'h0002A, 17'h10001, 17'h1003F, 17'h10001,
                            17'h1003F, 17'h0002B, 17'h10000, 17'h100EF,
                            17'h10000, 17'h100EF, 17'h0002C, 17'h10000};

  initial begin
    int t0;
    push_init();
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Requests before initialization must be dropped.
    repeat (3) @(posedge clk);
    #1 write_pixel = 1'b1;
    pixel_col = 9'd1;
    @(posedge clk);
    #1 write_pixel = 1'b0;
    repeat (20) @(posedge clk);
    #1 write_pixel = 1'b1;
    @(posedge clk);
    #1 write_pixel = 1'b0;
    wait_init(600);
    repeat (4) @(posedge clk);

    // Pixel (5,0) white, latency and literal words.
    t0 = tx_count;
    @(posedge clk);
    #1;
    pixel_col = 9'd5;
    pixel_row = 8'd0;
    bw = 1'b1;
    write_pixel = 1'b1;
    push_pixel(5, 0, 1);
    @(posedge clk);
    #1;
    pixel_col = 9'h1AA;
    pixel_row = 8'h77;
    bw = 1'b0;
    @(negedge clk);
    chk("lat_e0_wrx", tft_wrx, 1);
    @(posedge clk);
    #1 write_pixel = 1'b0;
    @(negedge clk);
    chk("lat_e1_wrx", tft_wrx, 1);
    @(negedge clk);
    chk("lat_e2_wrx", tft_wrx, 0);
    chk("lat_e2_csx", tft_csx, 0);
    wait_idle(200, 0);
    chk("t2_tx_count", tx_count - t0, 1);
    chk("t2_csx_len", last_len, 24);
    chk("t2_nwords", last_tx.size(), 12);
    for (int i = 0; i < 12 && i < last_tx.size(); i++)
      chk("t2_word", last_tx[i], lit2[i]);

    // Far corner, black.
    req(319, 239, 0, 1);
    wait_idle(200, 0);
    for (int i = 0; i < 12 && i < last_tx.size(); i++)
      chk("t3_word", last_tx[i], lit3[i]);

    // Edge while busy is dropped.
    t0 = tx_count;
    req(10, 20, 1, 1);
    repeat (6) @(posedge clk);
    #1 write_pixel = 1'b1;
    pixel_col = 9'd30;
    repeat (2) @(posedge clk);
    #1 write_pixel = 1'b0;
    wait_idle(200, 0);
    chk("t4_busy_drop", tx_count - t0, 1);

    // Out-of-range requests are ignored.
    t0 = tx_count;
    req(320, 5, 1, 1);
    repeat (40) @(posedge clk);
    req(7, 240, 0, 1);
    repeat (40) @(posedge clk);
    chk("t4_out_of_range", tx_count - t0, 0);

    // A held level does not retrigger.
    t0 = tx_count;
    req(12, 13, 0, 40);
    wait_idle(200, 0);
    chk("t4_level_hold", tx_count - t0, 1);

    // en=0 for 10 cycles mid-transaction.
    t0 = tx_count;
    req(100, 100, 1, 1);
    repeat (6) @(posedge clk);
    #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    wait_idle(200, 0);
    chk("t5_en_stall", tx_count - t0, 1);

    // Randomized requests with random enable gaps.
    for (int n = 0; n < 40; n++) begin
      req($urandom_range(0, 330), $urandom_range(0, 250),
          1'($urandom), $urandom_range(1, 3));
      wait_idle(400, 1);
    end

    // Reset mid-transaction.
    req(50, 60, 1, 1);
    repeat (8) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("async_reset",
        {initialized, tft_rst, tft_csx, tft_dcx,
         tft_wrx, tft_rdx, tft_data},
        {6'b001111, 16'h0000});
    exp_w.delete();
    exp_n.delete();
    push_init();
    @(posedge clk);
    #1 reset = 1'b1;
    wait_init(600);
    repeat (3) @(posedge clk);
    req(200, 100, 0, 2);
    wait_idle(200, 0);
    repeat (10) @(posedge clk);
    chk("exp_drained", exp_n.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/graphic_manager.md
Name: graphic_manager

Overview:
Drives an ILI9341 320x240 TFT panel over the 16-bit 8080-style parallel write interface. After reset it runs the panel power-up and initialization sequence autonomously, then asserts initialized. It then accepts single-pixel write requests with a column, row and black/white colour, and converts each into a window-set plus memory-write bus transaction. It sits between the drawing/canvas logic and the TFT pins.

Parameters:
RESET_LOW_CYCLES, 500, clk cycles tft_rst is held low at power-up (10 us at 50 MHz).
RESET_WAIT_CYCLES, 250000, wait after hardware reset release and after software reset command (5 ms).
SLEEP_OUT_CYCLES, 6000000, wait after Sleep Out command (120 ms).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous active-low reset.
en  in  1  clock enable; when 0 all state, counters and outputs hold.
pixel_col  in  9  pixel column, 0..319.
pixel_row  in  8  pixel row, 0..239.
write_pixel  in  1  write request; rising edge triggers a write.
bw_pixel_color  in  1  1 = white (0xFFFF), 0 = black (0x0000).
initialized  out  1  high once the init sequence completes; stays high until reset.
tft_rst  out  1  panel hardware reset, active low.
tft_csx  out  1  chip select, active low.
tft_dcx  out  1  0 = command word, 1 = data word.
tft_wrx  out  1  write strobe; panel latches on its rising edge.
tft_rdx  out  1  read strobe; constant 1.
tft_data  out  16  parallel bus. Commands and parameters use bits [7:0], with [15:8] = 0.

Behaviour:
- Reset values: tft_rst=0, tft_csx=1, tft_dcx=1, tft_wrx=1, tft_rdx=1, tft_data=0, initialized=0. The FSM returns to the reset-hold state.
- Bus word write takes 2 enabled cycles:
  - Cycle A: csx=0, dcx and data valid, wrx=0.
  - Cycle B: wrx=1, with data and dcx held.
- csx stays low across all words of one transaction and returns to 1 in the cycle after the last word.
- Init FSM states and sequence:
  - RST_LOW: tft_rst=0 for RESET_LOW_CYCLES.
  - RST_WAIT: tft_rst=1, wait RESET_WAIT_CYCLES.
  - Send cmd 0x01 (software reset); wait RESET_WAIT_CYCLES.
  - Send cmd 0x11 (sleep out); wait SLEEP_OUT_CYCLES.
  - Send cmd 0x3A, param 0x55 (16-bit RGB565).
  - Send cmd 0x36, param 0x28 (landscape, BGR).
  - Send cmd 0x29 (display on).
  - Enter IDLE; initialized=1 from the first IDLE cycle.
- tft_rst stays 1 from RST_WAIT onward.
- Pixel request:
  - write_pixel is registered. A 0->1 transition seen while in IDLE with initialized=1 latches pixel_col, pixel_row and bw_pixel_color. Inputs may then change freely.
  - Edges while busy or before initialization are dropped; they are not queued.
  - A level held high does not retrigger.
  - Requests with col>319 or row>239 are ignored; the FSM stays in IDLE.
- Pixel transaction, 12 words, 24 enabled cycles, single csx-low burst:
  - 0x2A, then params {7'b0,col[8]}, col[7:0], {7'b0,col[8]}, col[7:0].
  - 0x2B, then params 0x00, row, 0x00, row.
  - 0x2C, then data word 0xFFFF or 0x0000 with dcx=1.
  - Return to IDLE.
- Latency: first wrx falling edge occurs 2 cycles after the clock edge that samples the rising write_pixel.
- en=0 mid-transaction freezes the bus in its current state; operation resumes unchanged when en returns to 1.
- Reset mid-transaction aborts immediately to reset values and restarts the full init sequence.

Optional Feature:
CLEAR_ON_INIT_EN:
- Defined: after 0x29 and before IDLE, issue one transaction: CASET 0..319, PASET 0..239, 0x2C, then 76800 data words of 0x0000 with csx held low. initialized rises only after the fill completes.
- Undefined: no fill; initialized rises right after 0x29.

Test Plan:
1. Reset pulse (reset=0 for 1 cycle), en=1, small parameters (e.g. 4/8/8) -> tft_rst low for 4 cycles. Command bytes 0x01, 0x11, 0x3A/0x55, 0x36/0x28, 0x29 appear in order with dcx 0/1 correct. Then initialized=1.
2. After init, col=5, row=0, colour=1, write_pixel high for 2 cycles -> 12 words: 2A,00,05,00,05,2B,00,00,00,00,2C,FFFF. csx low for exactly 24 cycles; a single transaction.
3. col=319, row=239, colour=0 -> params 01,3F,01,3F and 00,EF,00,EF; data 0x0000.
4. Second write_pixel edge mid-transaction, and a request with col=320 -> both produce no bus activity.
5. en=0 for 10 cycles mid-transaction -> outputs frozen, then completion with identical words. Separately, write_pixel pulses before initialized -> ignored.
6. Assert reset during a pixel transaction -> outputs return to reset values immediately, initialized=0, and init restarts.
